// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator token sequencer
// Contents: token kinds, op codes, sequencer states, default data width and
// an op-code legality helper.
package calc_pkg;

  localparam int NB_DEFAULT = 48;

  typedef enum logic [1:0] {
    TOK_NUM = 2'd0,
    TOK_OP  = 2'd1,
    TOK_EQ  = 2'd2,
    TOK_CLR = 2'd3
  } tok_kind_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  // Codes above OP_POW have no calculator function behind them.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > OP_POW;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - token input and result output handshakes of the sequencer
// Signals: tok_valid/tok_ready/tok_kind/tok_data (token stream into the block),
//          res_valid/res_ready/res_data/res_err (result stream out of the block).
// master: token producer / result consumer. slave: the sequencer.
interface calc_sequencer_if #(
  parameter int nb = calc_pkg::NB_DEFAULT
);
  logic                 tok_valid;
  logic                 tok_ready;
  logic [1:0]           tok_kind;
  logic [nb-1:0]        tok_data;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [nb-1:0] res_data;
  logic                 res_err;

  modport master (
    output tok_valid, tok_kind, tok_data, res_ready,
    input  tok_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  tok_valid, tok_kind, tok_data, res_ready,
    output tok_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/calc_err_check.sv
// rtl/calc_err_check.sv - combinational error detection on the latched operation
// Ports: calc_op (latched op code), calc_b (latched B operand);
//        div0 (divide by zero), negexp (power with negative exponent), badop (illegal code).
module calc_err_check
  import calc_pkg::*;
#(
  parameter int nb = NB_DEFAULT
) (
  input  logic [2:0]           calc_op,
  input  logic signed [nb-1:0] calc_b,
  output logic                 div0,
  output logic                 negexp,
  output logic                 badop
);

  assign div0   = (calc_op == OP_DIV) && (calc_b == '0);
  assign negexp = (calc_op == OP_POW) && calc_b[nb-1];
  assign badop  = is_illegal_op(calc_op);

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - pocket-calculator style token sequencer around a combinational calculator
// Ports: clk, rst_n (async active-low); bus (token in / result out handshakes);
//        calc_a/calc_b/calc_op drive the calculator, calc_result is its output.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int nb = NB_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_sequencer_if.slave      bus,
  output logic signed [nb-1:0] calc_a,
  output logic signed [nb-1:0] calc_b,
  output logic [2:0]           calc_op,
  input  logic signed [nb-1:0] calc_result
);

  state_e               state_q;
  logic signed [nb-1:0] acc_q;
  logic signed [nb-1:0] b_q;
  logic [2:0]           op_q;
  logic                 err_q;
  logic signed [nb-1:0] res_data_q;
  logic                 res_err_q;

  logic      div0, negexp, badop;
  logic      exec_err;
  tok_kind_e kind;

  calc_err_check #(.nb(nb)) u_err_check (
    .calc_op (op_q),
    .calc_b  (b_q),
    .div0    (div0),
    .negexp  (negexp),
    .badop   (badop)
  );

  assign exec_err = div0 | negexp | badop;
  assign kind     = tok_kind_e'(bus.tok_kind);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_A;
      acc_q      <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      err_q      <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_A, S_OP, S_B: begin
          if (bus.tok_valid) begin
            if (kind == TOK_CLR) begin
              // CLR overrides any wrong-kind error that would otherwise be raised.
              state_q <= S_A;
              acc_q   <= '0;
              b_q     <= '0;
              op_q    <= OP_ADD;
              err_q   <= 1'b0;
            end else begin
              case (state_q)
                S_A: begin
                  if (kind == TOK_NUM) begin
                    acc_q   <= bus.tok_data;
                    state_q <= S_OP;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                S_OP: begin
                  if (kind == TOK_OP) begin
                    op_q    <= bus.tok_data[2:0];
                    state_q <= S_B;
                    if (is_illegal_op(bus.tok_data[2:0])) err_q <= 1'b1;
                  end else if (kind == TOK_EQ) begin
                    res_data_q <= err_q ? '0 : acc_q;
                    res_err_q  <= err_q;
                    state_q    <= S_OUT;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                default: begin  // S_B
                  if (kind == TOK_NUM) begin
                    b_q     <= bus.tok_data;
                    state_q <= S_EXEC;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
        S_EXEC: begin
          // Once err is set the accumulator is frozen until CLR or output handshake.
          if (exec_err) err_q <= 1'b1;
          else if (!err_q) acc_q <= calc_result;
          state_q <= S_OP;
        end
        S_OUT: begin
          if (bus.res_ready) begin
            err_q   <= 1'b0;
            state_q <= S_A;
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign bus.tok_ready = (state_q == S_A) || (state_q == S_OP) || (state_q == S_B);
  assign bus.res_valid = (state_q == S_OUT);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign calc_a        = acc_q;
  assign calc_b        = b_q;
  assign calc_op       = op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer with a behavioural calculator
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int NB = 48;

  logic clk;
  logic rst_n;
  logic signed [NB-1:0] calc_a, calc_b, calc_result;
  logic [2:0] calc_op;
  int checks;
  int errors;

  calc_sequencer_if #(.nb(NB)) bus ();

  calc_sequencer #(.nb(NB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .calc_a      (calc_a),
    .calc_b      (calc_b),
    .calc_op     (calc_op),
    .calc_result (calc_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational calculator.
  always_comb begin
    logic signed [NB-1:0] p;
    calc_result = '0;
    p = 1;
    case (calc_op)
      3'd0: calc_result = calc_a + calc_b;
      3'd1: calc_result = calc_a - calc_b;
      3'd2: calc_result = calc_a * calc_b;
      3'd3: calc_result = (calc_b == 0) ? '0 : calc_a / calc_b;
      3'd4: begin
        for (int i = 0; i < 64; i++) if (i < calc_b) p = p * calc_a;
        calc_result = (calc_b < 0) ? '0 : p;
      end
      default: calc_result = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input tok_kind_e k, input longint d);
    int cnt;
    cnt = 0;
    bus.tok_valid = 1'b1;
    bus.tok_kind  = k;
    bus.tok_data  = NB'(d);
    while (!bus.tok_ready && cnt < 50) begin
      step();
      cnt++;
    end
    checks++;
    if (!bus.tok_ready) begin
      errors++;
      $display("FAIL send_timeout: tok_ready=%0b required 1", bus.tok_ready);
    end
    step();
    bus.tok_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input longint exp_d, input logic exp_e);
    int cnt;
    logic signed [NB-1:0] e;
    e = NB'(exp_d);
    cnt = 0;
    while (!bus.res_valid && cnt < 20) begin
      step();
      cnt++;
    end
    checks++;
    if (bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: res_valid=%0b required 1", name, bus.res_valid);
    end
    checks++;
    if (bus.res_data !== e) begin
      errors++;
      $display("FAIL %s_data: res_data=%0d required %0d", name, bus.res_data, e);
    end
    checks++;
    if (bus.res_err !== exp_e) begin
      errors++;
      $display("FAIL %s_err: res_err=%0b required %0b", name, bus.res_err, exp_e);
    end
    bus.res_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tok_valid = 1'b0;
    bus.tok_kind  = 2'd0;
    bus.tok_data  = '0;
    bus.res_ready = 1'b1;
    #12;
    checks++;
    if (bus.tok_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== '0 ||
        bus.res_err !== 1'b0 || calc_a !== '0 || calc_b !== '0 || calc_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: tok_ready=%0b res_valid=%0b res_data=%0d res_err=%0b a=%0d b=%0d op=%0d required 1 0 0 0 0 0 0",
               bus.tok_ready, bus.res_valid, bus.res_data, bus.res_err, calc_a, calc_b, calc_op);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_timing();
    send(TOK_NUM, 7);
    send(TOK_OP, 0);
    send(TOK_NUM, 5);
    // Now in S_EXEC: no token accepted, accumulator not yet updated.
    checks++;
    if (bus.tok_ready !== 1'b0 || calc_a !== 48'sd7) begin
      errors++;
      $display("FAIL exec_cycle: tok_ready=%0b calc_a=%0d required 0 7", bus.tok_ready, calc_a);
    end
    step();
    checks++;
    if (bus.tok_ready !== 1'b1 || calc_a !== 48'sd12) begin
      errors++;
      $display("FAIL after_exec: tok_ready=%0b calc_a=%0d required 1 12", bus.tok_ready, calc_a);
    end
    send(TOK_EQ, 0);
    // res_valid must already be high one cycle after EQ acceptance.
    checks++;
    if (bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL eq_latency: res_valid=%0b required 1", bus.res_valid);
    end
    expect_result("add", 12, 1'b0);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.tok_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_handshake: res_valid=%0b tok_ready=%0b required 0 1", bus.res_valid, bus.tok_ready);
    end
  endtask

  task automatic test_chain();
    send(TOK_NUM, -6);
    send(TOK_OP, 2);
    send(TOK_NUM, 4);
    send(TOK_OP, 1);
    send(TOK_NUM, 10);
    send(TOK_EQ, 0);
    expect_result("chain", -34, 1'b0);
  endtask

  task automatic test_div0_then_clear();
    send(TOK_NUM, 9);
    send(TOK_OP, 3);
    send(TOK_NUM, 0);
    send(TOK_OP, 0);
    send(TOK_NUM, 1);
    send(TOK_EQ, 0);
    expect_result("div0", 0, 1'b1);
    send(TOK_NUM, 2);
    send(TOK_OP, 4);
    send(TOK_NUM, 3);
    send(TOK_EQ, 0);
    expect_result("pow_after_err", 8, 1'b0);
    send(TOK_NUM, 2);
    send(TOK_OP, 4);
    send(TOK_NUM, -1);
    send(TOK_EQ, 0);
    expect_result("negexp", 0, 1'b1);
  endtask

  task automatic test_bad_tokens();
    send(TOK_NUM, 3);
    send(TOK_OP, 5);
    checks++;
    if (calc_op !== 3'd5) begin
      errors++;
      $display("FAIL badop_latched: calc_op=%0d required 5", calc_op);
    end
    send(TOK_NUM, 1);
    send(TOK_EQ, 0);
    expect_result("badop", 0, 1'b1);
    send(TOK_NUM, 1);
    send(TOK_NUM, 2);
    send(TOK_EQ, 0);
    expect_result("wrong_kind", 0, 1'b1);
    // Wrong kind then CLR: error cleared, following expression clean.
    send(TOK_EQ, 0);
    send(TOK_CLR, 0);
    send(TOK_NUM, 20);
    send(TOK_OP, 1);
    send(TOK_NUM, 25);
    send(TOK_EQ, 0);
    expect_result("clr_clears_err", -5, 1'b0);
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    send(TOK_NUM, 4);
    send(TOK_OP, 2);
    send(TOK_NUM, 4);
    send(TOK_EQ, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 48'sd16 || bus.tok_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: res_valid=%0b res_data=%0d tok_ready=%0b required 1 16 0",
                 i, bus.res_valid, bus.res_data, bus.tok_ready);
      end
      step();
    end
    bus.res_ready = 1'b1;
    step();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.tok_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: res_valid=%0b tok_ready=%0b required 0 1", bus.res_valid, bus.tok_ready);
    end
  endtask

  task automatic test_reset_and_clr();
    send(TOK_NUM, 5);
    send(TOK_OP, 0);
    send(TOK_NUM, 3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.tok_ready !== 1'b1 || calc_a !== '0 || calc_b !== '0 || calc_op !== 3'd0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_exec: tok_ready=%0b a=%0d b=%0d op=%0d res_valid=%0b required 1 0 0 0 0",
               bus.tok_ready, calc_a, calc_b, calc_op, bus.res_valid);
    end
    #3;
    rst_n = 1'b1;
    step();
    send(TOK_NUM, 1);
    send(TOK_OP, 0);
    send(TOK_NUM, 1);
    send(TOK_EQ, 0);
    expect_result("after_reset", 2, 1'b0);
    send(TOK_NUM, 5);
    send(TOK_OP, 2);
    send(TOK_CLR, 0);
    checks++;
    if (bus.tok_ready !== 1'b1 || calc_a !== '0 || calc_b !== '0 || calc_op !== 3'd0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_in_b: tok_ready=%0b a=%0d b=%0d op=%0d res_valid=%0b required 1 0 0 0 0",
               bus.tok_ready, calc_a, calc_b, calc_op, bus.res_valid);
    end
    send(TOK_NUM, 1);
    send(TOK_OP, 0);
    send(TOK_NUM, 1);
    send(TOK_EQ, 0);
    expect_result("after_clr", 2, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_timing();
    test_chain();
    test_div0_then_clear();
    test_bad_tokens();
    test_backpressure();
    test_reset_and_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
